// File: rtl/anton_neopixel_apb_feeder_pkg.sv
// Shared constants and state encoding for the neopixel APB feeder.
package anton_neopixel_apb_feeder_pkg;

   // Region codes carried on paddr[19:18] of the neopixel slave
   localparam logic [1:0]  RGN_RAW      = 2'b11;
   localparam logic [1:0]  RGN_VIRTUAL  = 2'b10;
   localparam logic [1:0]  RGN_DELTAS   = 2'b01;
   localparam logic [1:0]  RGN_CTRL     = 2'b00;

   // Control register location and the value that kicks off a refresh
   localparam logic [19:0] CTRL_ADDR_DEF  = 20'h00004;
   localparam logic [7:0]  CTRL_START_DEF = 8'h01;

   // Last raw-buffer byte index; must match the slave's setting
   localparam int          BUFFER_END_DEFAULT = 1023;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_CTRL_SETUP,
      ST_CTRL_ACCESS,
      ST_DONE
   } feeder_state_t;

endpackage

// File: rtl/anton_neopixel_apb_feeder_master_port.sv
// Single-write APB sequencer: SETUP then ACCESS, finishing on pready or timeout.
// Holding i_req high across an ack starts a fresh SETUP for the next write.
module anton_apb_master_port #(
   parameter int TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic [19:0] i_addr,
   input  logic [7:0]  i_data,
   input  logic        i_pready,
   input  logic        i_pslverr,
   output logic        o_psel,
   output logic        o_penable,
   output logic        o_pwrite,
   output logic [19:0] o_paddr,
   output logic [7:0]  o_pwdata,
   output logic        o_ack,
   output logic        o_err
);

   logic       r_en;
   logic [7:0] r_cnt;
   logic       w_timeout;

   assign o_psel    = i_req;
   assign o_penable = i_req & r_en;
   assign o_pwrite  = i_req;
   assign o_paddr   = i_req ? i_addr : 20'h0;
   assign o_pwdata  = i_req ? i_data : 8'h0;

   // r_cnt holds the number of ACCESS cycles already spent waiting
   assign w_timeout = o_penable & ~i_pready & (r_cnt == 8'(TIMEOUT - 1));
   assign o_ack     = o_penable & (i_pready | w_timeout);
   assign o_err     = o_ack & (~i_pready | i_pslverr);

   // Phase bit (setup/access) and wait counter; both restart after every ack
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_en  <= 1'b0;
         r_cnt <= 8'd0;
      end else begin
         r_en  <= i_req & ~o_ack;
         r_cnt <= (o_penable & ~o_ack) ? r_cnt + 8'd1 : 8'd0;
      end
   end

endmodule

// File: rtl/anton_neopixel_apb_feeder.sv
// Streams pixel bytes into the neopixel raw buffer over APB, then writes the
// control register to start a refresh at end of frame.
module anton_neopixel_apb_feeder
   import anton_neopixel_apb_feeder_pkg::*;
#(
   parameter int          BUFFER_END = BUFFER_END_DEFAULT,
   parameter logic [1:0]  REGION_RAW = RGN_RAW,
   parameter logic [19:0] CTRL_ADDR  = CTRL_ADDR_DEF,
   parameter logic [7:0]  CTRL_START = CTRL_START_DEF,
   parameter int          TIMEOUT    = 255
) (
   input  logic        apbPclk,
   input  logic        apbPreset,
   input  logic        pixValid,
   input  logic [7:0]  pixData,
   input  logic        pixLast,
   output logic        pixReady,
   output logic        apbPselx,
   output logic        apbPenable,
   output logic        apbPwrite,
   output logic [19:0] apbPaddr,
   output logic [7:0]  apbPwData,
   input  logic        apbPready,
   input  logic        apbPslverr,
   output logic        busy,
   output logic        frameDone,
   output logic        overflow,
   output logic        busErr
);

   // One bit wider than a 16-bit index so the count can rest at BUFFER_END+1
   localparam int            IW  = 17;
   localparam logic [IW-1:0] LIM = IW'(BUFFER_END);

   feeder_state_t r_state, w_next;
   logic [IW-1:0] r_idx;
   logic [15:0]   r_cidx;
   logic [7:0]    r_byte;
   logic          r_last, r_busy, r_ovf, r_err;
   logic          w_accept, w_in_range, w_req, w_ack, w_err;
   logic [19:0]   w_addr;
   logic [7:0]    w_data;

   assign pixReady   = (r_state == ST_IDLE) & ~apbPreset;
   assign w_accept   = pixReady & pixValid;
   assign w_in_range = (r_idx <= LIM);
   assign busy       = r_busy;
   assign frameDone  = (r_state == ST_DONE);
   assign overflow   = r_ovf;
   assign busErr     = r_err;

   // Next state plus the request/address/data fed to the APB port
   always_comb begin
      w_next = r_state;
      w_req  = 1'b0;
      w_addr = {REGION_RAW, r_cidx, 2'b00};
      w_data = r_byte;
      case (r_state)
         ST_IDLE: begin
            if (pixValid) begin
               if (w_in_range)   w_next = ST_SETUP;
               else if (pixLast) w_next = ST_CTRL_SETUP;
            end
         end
         ST_SETUP: begin
            w_req  = 1'b1;
            w_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            w_req = 1'b1;
            if (w_ack) w_next = r_last ? ST_CTRL_SETUP : ST_IDLE;
         end
         ST_CTRL_SETUP: begin
            w_req  = 1'b1;
            w_addr = CTRL_ADDR;
            w_data = CTRL_START;
            w_next = ST_CTRL_ACCESS;
         end
         ST_CTRL_ACCESS: begin
            w_req  = 1'b1;
            w_addr = CTRL_ADDR;
            w_data = CTRL_START;
            if (w_ack) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // State register, byte capture, index and sticky status flags
   always_ff @(posedge apbPclk) begin
      if (apbPreset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cidx  <= '0;
         r_byte  <= '0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_byte <= pixData;
            r_last <= pixLast;
            r_cidx <= r_idx[15:0];
            r_busy <= 1'b1;
            if (r_idx == '0) r_ovf <= 1'b0;
            if (w_in_range) r_idx <= r_idx + 1'b1;
            else            r_ovf <= 1'b1;
         end
         if (w_err) r_err <= 1'b1;
         // busy falls as DONE is entered so it is already low during frameDone
         if (r_state == ST_CTRL_ACCESS && w_ack) r_busy <= 1'b0;
         if (r_state == ST_DONE) r_idx <= '0;
      end
   end

   anton_apb_master_port #(.TIMEOUT(TIMEOUT)) u_port (
      .i_clk     (apbPclk),
      .i_rst     (apbPreset),
      .i_req     (w_req),
      .i_addr    (w_addr),
      .i_data    (w_data),
      .i_pready  (apbPready),
      .i_pslverr (apbPslverr),
      .o_psel    (apbPselx),
      .o_penable (apbPenable),
      .o_pwrite  (apbPwrite),
      .o_paddr   (apbPaddr),
      .o_pwdata  (apbPwData),
      .o_ack     (w_ack),
      .o_err     (w_err)
   );

endmodule

// File: tb/tb_anton_neopixel_apb_feeder.sv
// Bench for the neopixel APB feeder: pixel table, scoreboarded APB slave.
module tb_anton_neopixel_apb_feeder;

   logic        apbPclk = 1'b0;
   logic        apbPreset, pixValid, pixLast, apbPready, apbPslverr;
   logic [7:0]  pixData;
   logic        pixReady, apbPselx, apbPenable, apbPwrite;
   logic [19:0] apbPaddr;
   logic [7:0]  apbPwData;
   logic        busy, frameDone, overflow, busErr;

   always #5 apbPclk = ~apbPclk;

   anton_neopixel_apb_feeder #(.BUFFER_END(3), .TIMEOUT(8)) dut (
      .apbPclk(apbPclk), .apbPreset(apbPreset),
      .pixValid(pixValid), .pixData(pixData), .pixLast(pixLast), .pixReady(pixReady),
      .apbPselx(apbPselx), .apbPenable(apbPenable), .apbPwrite(apbPwrite),
      .apbPaddr(apbPaddr), .apbPwData(apbPwData),
      .apbPready(apbPready), .apbPslverr(apbPslverr),
      .busy(busy), .frameDone(frameDone), .overflow(overflow), .busErr(busErr)
   );

   typedef struct {logic [7:0] d; logic last; logic wr; logic [19:0] a;} vec_t;
   typedef struct {logic [19:0] a; logic [7:0] d;} wr_t;

   vec_t        tbl[16];
   wr_t         exp_q[$];
   int          checks = 0, errors = 0;
   int          cyc = 0;
   int          ws = 0;
   bit          hang = 0;
   int          err_at = -1;
   int          wr_done = 0, wcnt = 0, run = 0, last_run = 0;
   int          done_cnt = 0, done_cyc = 0, ctrl_cyc = 0;
   logic [19:0] setup_a = '0;
   logic [7:0]  setup_d = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge apbPclk) cyc <= cyc + 1;

   // Slave model and write scoreboard, evaluated mid-cycle
   initial begin
      wr_t e;
      apbPready = 1'b0; apbPslverr = 1'b0;
      forever begin
         @(negedge apbPclk);
         if (apbPselx === 1'b1 && apbPenable === 1'b1) begin
            apbPready  = !hang && (wcnt >= ws);
            apbPslverr = apbPready && (wr_done == err_at);
            wcnt++; run++;
         end else begin
            apbPready = 1'b0; apbPslverr = 1'b0; wcnt = 0;
            if (run > 0) last_run = run;
            run = 0;
            if (apbPselx === 1'b1) begin setup_a = apbPaddr; setup_d = apbPwData; end
         end
         #1;
         if (apbPselx === 1'b1 && apbPenable === 1'b1 && apbPready) begin
            chk("pwrite", {31'd0, apbPwrite}, 32'd1);
            chk("addr_stable", {12'd0, apbPaddr}, {12'd0, setup_a});
            chk("data_stable", {24'd0, apbPwData}, {24'd0, setup_d});
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got addr %0h data %0h want none", apbPaddr, apbPwData);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", {12'd0, apbPaddr}, {12'd0, e.a});
               chk("wr_data", {24'd0, apbPwData}, {24'd0, e.d});
            end
            if (apbPaddr == 20'h00004) ctrl_cyc = cyc;
            wr_done++;
         end
         if (frameDone === 1'b1) begin done_cnt++; done_cyc = cyc; end
      end
   end

   task automatic send(input logic [7:0] d, input logic l, output int acc);
      int n = 0;
      @(negedge apbPclk);
      pixValid = 1'b1; pixData = d; pixLast = l;
      #1;
      while (!pixReady && n < 200) begin @(negedge apbPclk); #1; n++; end
      if (!pixReady) begin
         checks++; errors++;
         $display("FAIL send_ready: got pixReady 0 want 1 within 200 cycles");
      end
      acc = cyc;
      @(posedge apbPclk); #1;
      pixValid = 1'b0; pixLast = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!pixReady && n < 200) begin @(negedge apbPclk); #2; n++; end
      chk("wait_ready", {31'd0, pixReady}, 32'd1);
   endtask

   task automatic run_frame(input int lo, input int hi, input int w);
      int prev = -1, acc = 0, n = 0, d0;
      d0 = done_cnt;
      ws = w;
      for (int i = lo; i <= hi; i++) begin
         if (tbl[i].wr) exp_q.push_back('{tbl[i].a, tbl[i].d});
         if (tbl[i].last) exp_q.push_back('{20'h00004, 8'h01});
         send(tbl[i].d, tbl[i].last, acc);
         if (i == lo) begin
            chk("busy_first", {31'd0, busy}, 32'd1);
            chk("ovf_clear_first", {31'd0, overflow}, 32'd0);
         end
         if (w == 0 && i > lo && tbl[i-1].wr) chk("ready_period", acc - prev, 32'd3);
         prev = acc;
      end
      while (done_cnt == d0 && n < 300) begin @(negedge apbPclk); #2; n++; end
      repeat (3) @(negedge apbPclk);
      #2;
      chk("done_once", done_cnt - d0, 32'd1);
      chk("done_after_ctrl", done_cyc - ctrl_cyc, 32'd1);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("busy_end", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int acc, d0, n;
      tbl[0]  = '{8'h11, 1'b0, 1'b1, 20'hC0000};
      tbl[1]  = '{8'h22, 1'b0, 1'b1, 20'hC0004};
      tbl[2]  = '{8'h33, 1'b0, 1'b1, 20'hC0008};
      tbl[3]  = '{8'h44, 1'b1, 1'b1, 20'hC000C};
      tbl[4]  = '{8'hB0, 1'b0, 1'b1, 20'hC0000};
      tbl[5]  = '{8'hB1, 1'b0, 1'b1, 20'hC0004};
      tbl[6]  = '{8'hB2, 1'b0, 1'b1, 20'hC0008};
      tbl[7]  = '{8'hB3, 1'b0, 1'b1, 20'hC000C};
      tbl[8]  = '{8'hB4, 1'b0, 1'b0, 20'h00000};
      tbl[9]  = '{8'hB5, 1'b1, 1'b0, 20'h00000};
      tbl[10] = '{8'hA1, 1'b0, 1'b1, 20'hC0000};
      tbl[11] = '{8'hA2, 1'b0, 1'b1, 20'hC0004};
      tbl[12] = '{8'hA3, 1'b0, 1'b1, 20'hC0008};
      tbl[13] = '{8'hA4, 1'b1, 1'b1, 20'hC000C};
      tbl[14] = '{8'h66, 1'b1, 1'b1, 20'hC0004};
      tbl[15] = '{8'h88, 1'b1, 1'b1, 20'hC0000};

      apbPreset = 1'b1; pixValid = 1'b0; pixData = 8'h00; pixLast = 1'b0;
      repeat (3) @(posedge apbPclk);
      #1;
      chk("rst_pixReady", {31'd0, pixReady}, 32'd0);
      chk("rst_psel", {31'd0, apbPselx}, 32'd0);
      chk("rst_penable", {31'd0, apbPenable}, 32'd0);
      chk("rst_pwrite", {31'd0, apbPwrite}, 32'd0);
      chk("rst_paddr", {12'd0, apbPaddr}, 32'd0);
      chk("rst_pwdata", {24'd0, apbPwData}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, frameDone}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_buserr", {31'd0, busErr}, 32'd0);
      @(negedge apbPclk);
      apbPreset = 1'b0;

      // zero wait states, then two wait states
      run_frame(0, 3, 0);
      chk("a_ovf", {31'd0, overflow}, 32'd0);
      chk("a_buserr", {31'd0, busErr}, 32'd0);
      run_frame(0, 3, 2);
      chk("b_buserr", {31'd0, busErr}, 32'd0);

      // six bytes into a four-byte buffer
      run_frame(4, 9, 0);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_buserr", {31'd0, busErr}, 32'd0);

      // slave error on the second write of the frame
      err_at = wr_done + 1;
      run_frame(10, 13, 0);
      err_at = -1;
      chk("slverr_sticky", {31'd0, busErr}, 32'd1);
      chk("slverr_ovf", {31'd0, overflow}, 32'd0);

      // slave never ready: timeout after 8 ACCESS cycles
      hang = 1'b1;
      send(8'h55, 1'b0, acc);
      wait_ready();
      chk("timeout_len", last_run, 32'd8);
      chk("timeout_psel", {31'd0, apbPselx}, 32'd0);
      chk("timeout_buserr", {31'd0, busErr}, 32'd1);
      chk("timeout_busy", {31'd0, busy}, 32'd1);
      hang = 1'b0;
      run_frame(14, 14, 0);

      // reset while in ACCESS
      hang = 1'b1;
      d0 = done_cnt;
      send(8'h77, 1'b0, acc);
      n = 0;
      while (apbPenable !== 1'b1 && n < 50) begin @(negedge apbPclk); #2; n++; end
      chk("reach_access", {31'd0, apbPenable}, 32'd1);
      apbPreset = 1'b1;
      @(posedge apbPclk); #1;
      chk("rstmid_psel", {31'd0, apbPselx}, 32'd0);
      chk("rstmid_penable", {31'd0, apbPenable}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      @(negedge apbPclk);
      apbPreset = 1'b0;
      hang = 1'b0;
      repeat (5) @(negedge apbPclk);
      #2;
      chk("rstmid_no_done", done_cnt - d0, 32'd0);
      run_frame(15, 15, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
